// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int ITER_MAX = 16;

   // Gain K after 16 micro-rotations; the datapath does not compensate it.
   localparam real CORDIC_GAIN = 1.6467602581210654;

   // round(atan(2^-i) * 2^m / pi); evaluated at elaboration only.
   function automatic logic [63:0] atan_lut(input int i, input int m);
      real a;
      a = $atan(2.0 ** (-i)) * (2.0 ** m) / 3.14159265358979323846;
      return 64'(longint'(a));
   endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation in rotation mode (drive z toward 0).
module cordic_rot_step
   import cordic_pkg::*;
#(
   parameter int N = 31,
   parameter int M = 31
) (
   input  logic signed [N:0] x,
   input  logic signed [N:0] y,
   input  logic signed [M:0] z,
   input  logic        [3:0] shift,
   input  logic signed [M:0] atan_val,
   output logic signed [N:0] x_nxt,
   output logic signed [N:0] y_nxt,
   output logic signed [M:0] z_nxt
);

   logic signed [N:0] xs;
   logic signed [N:0] ys;

   assign xs = x >>> shift;
   assign ys = y >>> shift;

   always_comb begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan_val;
      if (z[M]) begin
         x_nxt = x + ys;
         y_nxt = y - xs;
         z_nxt = z + atan_val;
      end
   end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator, one micro-rotation per clock, valid/ready on both sides.
// Optional CORDIC_QUAD_CORRECT_EN folds a +/-90 degree pre-rotation into the load.
module cordic_rotator
   import cordic_pkg::*;
#(
   parameter int N    = 31,
   parameter int M    = 31,
   parameter int ITER = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [N:0] x_in,
   input  logic signed [N:0] y_in,
   input  logic signed [M:0] angle_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [N:0] x_out,
   output logic signed [N:0] y_out
);

   localparam logic [3:0] LAST = 4'(ITER - 1);

   state_e                  state;
   logic              [3:0] cnt;
   logic signed       [N:0] xr, yr, xn, yn, x_ld, y_ld;
   logic signed       [M:0] zr, zn, z_ld;
   logic [ITER_MAX-1:0][M:0] atan_tab;

   for (genvar g = 0; g < ITER_MAX; g++) begin : g_lut
      localparam logic [63:0] LUT = atan_lut(g, M);
      assign atan_tab[g] = LUT[M:0];
   end

`ifdef CORDIC_QUAD_CORRECT_EN
   localparam logic signed [M:0] HALF = {2'b01, {(M-1){1'b0}}};

   // Beyond +/-pi/2 swap axes so the residual angle stays in CORDIC range.
   always_comb begin
      x_ld = x_in;
      y_ld = y_in;
      z_ld = angle_in;
      if (angle_in > HALF) begin
         x_ld = -y_in;
         y_ld = x_in;
         z_ld = angle_in - HALF;
      end else if (angle_in < -HALF) begin
         x_ld = y_in;
         y_ld = -x_in;
         z_ld = angle_in + HALF;
      end
   end
`else
   assign x_ld = x_in;
   assign y_ld = y_in;
   assign z_ld = angle_in;
`endif

   cordic_rot_step #(.N(N), .M(M)) u_step (
      .x        (xr),
      .y        (yr),
      .z        (zr),
      .shift    (cnt),
      .atan_val (atan_tab[cnt]),
      .x_nxt    (xn),
      .y_nxt    (yn),
      .z_nxt    (zn)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         xr    <= '0;
         yr    <= '0;
         zr    <= '0;
         x_out <= '0;
         y_out <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               xr    <= x_ld;
               yr    <= y_ld;
               zr    <= z_ld;
               cnt   <= '0;
               state <= ROTATE;
            end
            ROTATE: begin
               xr <= xn;
               yr <= yn;
               zr <= zn;
               if (cnt == LAST) begin
                  x_out <= xn;
                  y_out <= yn;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: real-arithmetic rotation model, latency and hold checks.
module tb_cordic_rotator;

   localparam int  N    = 31;
   localparam int  M    = 31;
   localparam int  ITER = 16;
   localparam int  TOL  = 64;
   localparam real PI   = 3.14159265358979323846;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b1;
   logic              in_ready, out_valid;
   logic signed [N:0] x_in = '0, y_in = '0;
   logic signed [M:0] angle_in = '0;
   logic signed [N:0] x_out, y_out;

   always #5 clk = ~clk;

   cordic_rotator #(.N(N), .M(M), .ITER(ITER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .angle_in  (angle_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out)
   );

   typedef struct { int x; int y; } exp_t;
   exp_t   exp_q[$];
   longint acc_q[$];
   int     compared = 0;
   int     mismatched = 0;
   longint cyc = 0;
   int     rdy_mode = 1;

   task automatic chk(input string name, input longint act, input longint req, input longint tol);
      compared++;
      if (act > req + tol || act < req - tol) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d", name, act, req, tol, cyc);
      end
   endtask

   // Ideal rotation by the angle the micro-rotation decisions actually sum to, times K.
   function automatic void model(input int xi, input int yi, input int ai, output int ex, output int ey);
      longint x0, y0, z, h, lut;
      real    phi, k, a;
      x0 = xi; y0 = yi; z = ai;
      h = longint'(1) << (M - 1);
      phi = 0.0; k = 1.0;
`ifdef CORDIC_QUAD_CORRECT_EN
      if (z > h) begin
         x0 = -longint'(yi); y0 = xi; z = z - h;
      end else if (z < -h) begin
         x0 = yi; y0 = -longint'(xi); z = z + h;
      end
`endif
      for (int i = 0; i < ITER; i++) begin
         a   = $atan(2.0 ** (-i));
         lut = longint'(a * (2.0 ** M) / PI);
         if (z >= 0) begin phi += a; z -= lut; end
         else        begin phi -= a; z += lut; end
         k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
      end
      ex = int'(k * (real'(x0) * $cos(phi) - real'(y0) * $sin(phi)));
      ey = int'(k * (real'(x0) * $sin(phi) + real'(y0) * $cos(phi)));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic              prev_ov = 1'b0;
   logic signed [N:0] hx = '0, hy = '0;

   always @(negedge clk) begin
      exp_t   e;
      longint a;
      if (!rst_n) begin
         prev_ov <= 1'b0;
      end else begin
         if (out_valid) begin
            chk("in_ready_while_done", 64'(in_ready), 0, 0);
            if (!prev_ov) begin
               if (acc_q.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL unexpected_result: out_valid with no accepted operation");
               end else begin
                  a = acc_q.pop_front();
                  chk("latency", cyc - a, ITER, 0);
               end
            end else begin
               chk("hold_x", x_out, hx, 0);
               chk("hold_y", y_out, hy, 0);
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL unexpected_result: x=%0d y=%0d", x_out, y_out);
               end else begin
                  e = exp_q.pop_front();
                  chk("x_out", x_out, e.x, TOL);
                  chk("y_out", y_out, e.y, TOL);
               end
            end
         end
         prev_ov <= out_valid;
         hx      <= x_out;
         hy      <= y_out;
      end
   end

   task automatic send(input int xi, input int yi, input int ai);
      exp_t e;
      int   n;
      model(xi, yi, ai, e.x, e.y);
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b1; x_in = xi; y_in = yi; angle_in = ai;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 500) break;
      end
      if (n > 500) begin
         compared++; mismatched++;
         $display("FAIL accept_timeout: in_ready=%0d, expected 1", in_ready);
         void'(exp_q.pop_back());
      end else begin
         acc_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_left", exp_q.size(), 0, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  64'(in_ready),  1, 0);
      chk({tag, "_out_valid"}, 64'(out_valid), 0, 0);
      chk({tag, "_x_out"},     x_out, 0, 0);
      chk({tag, "_y_out"},     y_out, 0, 0);
   endtask

   function automatic int rnd_data();
      return int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000;
   endfunction

   initial begin
      rdy_mode = 1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 0, 0);
      chk("idle_in_ready",  64'(in_ready),  1, 0);

      // zero, +pi/4, +pi/2, -pi/2 (2^M is pi)
      send(1 << 20, 0, 0);
      send(1 << 20, 0, 1 << (M - 2));
      send(1 << 20, 0, 1 << (M - 1));
      send(1 << 20, 0, -(1 << (M - 1)));
      send(-(1 << 22), 3 << 20, -(1 << (M - 3)));
`ifdef CORDIC_QUAD_CORRECT_EN
      send(1 << 20, 0, 32'sh8000_0000);
      send(1 << 20, 0, 3 << (M - 2));
`endif
      drain();

      rdy_mode = 2;
      repeat (30) begin
`ifdef CORDIC_QUAD_CORRECT_EN
         send(rnd_data(), rnd_data(), int'($urandom()));
`else
         send(rnd_data(), rnd_data(), int'($urandom_range(0, 32'h8000_0000)) - 32'sh4000_0000);
`endif
      end
      rdy_mode = 1;
      drain();

      // backpressure with stray in_valid while busy
      rdy_mode = 0;
      send(12345678, -7654321, 1 << (M - 3));
      @(posedge clk); #1;
      in_valid = 1'b1; x_in = 32'sh0100_0000; y_in = 32'sh0100_0000; angle_in = 32'sh1000_0000;
      repeat (3) begin
         @(negedge clk);
         chk("busy_in_ready", 64'(in_ready), 0, 0);
      end
      begin
         int n;
         n = 0;
         while (!out_valid && n < 100) begin @(negedge clk); n++; end
         chk("bp_out_valid_seen", 64'(out_valid), 1, 0);
      end
      repeat (10) @(negedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      rdy_mode = 1;
      send(1 << 20, 0, 0);
      drain();

      // reset at the 7th iteration
      send(1 << 20, 3 << 20, 123456789);
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midop_reset");
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      repeat (2) @(negedge clk);
      chk_reset_outputs("held_reset");
      @(posedge clk); #1 rst_n = 1'b1;
      send(1 << 20, 0, 0);
      drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
